// File: rtl/freq_divider_cond.sv
// Phase-locked /2, /4, /8 clock conditioner driven by one free-running counter.
// Optional /16 output enabled by defining FREQ_DIV_CLK16_EN.
module freq_divider_cond (
  input  logic CLK,
  input  logic reset,
  output logic CLK_2,
  output logic CLK_4,
  output logic CLK_8
`ifdef FREQ_DIV_CLK16_EN
  ,
  output logic CLK_16
`endif
);

`ifdef FREQ_DIV_CLK16_EN
  localparam int CW = 4;
`else
  localparam int CW = 3;
`endif

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_div;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_div_nxt;

  // Next counter value and next divided-clock phases from the pre-increment count
  always_comb begin
    w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
    w_div_nxt = ~r_cnt;
  end

  // Free-running phase counter, cleared asynchronously
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_cnt <= {CW{1'b0}};
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Output flops: each divided clock is a registered inverted counter bit
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_div <= {CW{1'b0}};
    end else begin
      r_div <= w_div_nxt;
    end
  end

  assign CLK_2  = r_div[0];
  assign CLK_4  = r_div[1];
  assign CLK_8  = r_div[2];
`ifdef FREQ_DIV_CLK16_EN
  assign CLK_16 = r_div[3];
`endif

endmodule

// File: tb/tb_freq_divider_cond.sv
// Directed self-checking bench for freq_divider_cond (both FREQ_DIV_CLK16_EN builds).
module tb_freq_divider_cond;

  logic clk;
  logic rst_n;
  logic clk_2;
  logic clk_4;
  logic clk_8;
`ifdef FREQ_DIV_CLK16_EN
  logic clk_16;
`endif

  int n_checks;
  int n_errors;

  freq_divider_cond u_dut (
    .CLK   (clk),
    .reset (rst_n),
    .CLK_2 (clk_2),
    .CLK_4 (clk_4),
    .CLK_8 (clk_8)
`ifdef FREQ_DIV_CLK16_EN
    ,
    .CLK_16(clk_16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hand-computed edge 1..8 sequences, bit 7 = edge 1
  logic [7:0] seq2;
  logic [7:0] seq4;
  logic [7:0] seq8;

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_release_seq(input string tag);
    for (int k = 1; k <= 8; k++) begin
      step_edge();
      check_val({tag, "_clk2"}, {31'd0, clk_2}, {31'd0, seq2[8-k]});
      check_val({tag, "_clk4"}, {31'd0, clk_4}, {31'd0, seq4[8-k]});
      check_val({tag, "_clk8"}, {31'd0, clk_8}, {31'd0, seq8[8-k]});
    end
  endtask

  initial begin
    int last_rise2, last_rise4, last_rise8;
    logic p2, p4, p8;
    n_checks = 0;
    n_errors = 0;
    seq2 = 8'b1010_1010;
    seq4 = 8'b1100_1100;
    seq8 = 8'b1111_0000;
    rst_n = 1'b0;

    // Reset hold across two edges
    for (int i = 0; i < 2; i++) begin
      step_edge();
      check_val("hold_outs", {29'd0, clk_8, clk_4, clk_2}, 32'd0);
    end

    release_reset();
    check_release_seq("rel");

    // Long run continuing from edge 9: model check plus period and phase-lock checks
    last_rise2 = -1;
    last_rise4 = -1;
    last_rise8 = -1;
    p2 = clk_2;
    p4 = clk_4;
    p8 = clk_8;
    for (int k = 9; k < 9 + 64; k++) begin
      step_edge();
      check_val("long_clk2", {31'd0, clk_2}, {31'd0, ((k - 1) % 2) < 1});
      check_val("long_clk4", {31'd0, clk_4}, {31'd0, ((k - 1) % 4) < 2});
      check_val("long_clk8", {31'd0, clk_8}, {31'd0, ((k - 1) % 8) < 4});
      if (!p2 && clk_2) begin
        if (last_rise2 >= 0) check_val("per2", k - last_rise2, 32'd2);
        last_rise2 = k;
      end
      if (!p4 && clk_4) begin
        if (last_rise4 >= 0) check_val("per4", k - last_rise4, 32'd4);
        last_rise4 = k;
      end
      if (!p8 && clk_8) begin
        if (last_rise8 >= 0) check_val("per8", k - last_rise8, 32'd8);
        last_rise8 = k;
        check_val("lock8", {30'd0, !p4 && clk_4, !p2 && clk_2}, 32'd3);
      end
      p2 = clk_2;
      p4 = clk_4;
      p8 = clk_8;
    end
    check_val("long_rises_seen", {31'd0, (last_rise8 > 0) && (last_rise4 > 0) && (last_rise2 > 0)}, 32'd1);

    // Async reset between edges 5 and 6
    rst_n = 1'b0;
    step_edge();
    release_reset();
    for (int k = 1; k <= 5; k++) step_edge();
    check_val("pre_mid_rst", {29'd0, clk_8, clk_4, clk_2}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_async", {29'd0, clk_8, clk_4, clk_2}, 32'd0);
    step_edge();
    check_val("mid_rst_hold", {29'd0, clk_8, clk_4, clk_2}, 32'd0);
    release_reset();
    check_release_seq("rerel");

`ifdef FREQ_DIV_CLK16_EN
    rst_n = 1'b0;
    step_edge();
    check_val("rst_clk16", {31'd0, clk_16}, 32'd0);
    release_reset();
    for (int k = 1; k <= 16; k++) begin
      step_edge();
      check_val("c16_clk16", {31'd0, clk_16}, {31'd0, k <= 8});
      check_val("c16_clk2", {31'd0, clk_2}, {31'd0, seq2[7 - ((k - 1) % 8)]});
      check_val("c16_clk4", {31'd0, clk_4}, {31'd0, seq4[7 - ((k - 1) % 8)]});
      check_val("c16_clk8", {31'd0, clk_8}, {31'd0, seq8[7 - ((k - 1) % 8)]});
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
